// File: rtl/vsi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vsi_pkg : shared types and constants for one VSI inverter leg     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package vsi_pkg;

  localparam int DT_W_DEF   = 8;
  localparam int PWM_PERIOD = 1000;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_DEAD_H = 3'd1,
    ST_HIGH   = 3'd2,
    ST_DEAD_L = 3'd3,
    ST_LOW    = 3'd4
  } leg_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_ff : two-flop synchronizer with selectable reset value       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module sync_ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {2{RST_VAL}};
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/deadtime_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | deadtime_gen : complementary gate drive with break-before-make    |
// |                dead time and latched driver-fault shutdown        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module deadtime_gen
  import vsi_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            s,
  input  logic [DT_W-1:0] dt,
  input  logic            fault_n,
  input  logic            clr_fault,
  output logic            gh,
  output logic            gl,
  output logic            fault
);

  localparam logic [DT_W-1:0] C_DT_ONE = {{(DT_W-1){1'b0}}, 1'b1};

  leg_state_e      r_state;
  logic [DT_W-1:0] r_cnt;
  logic            r_s_q;
  logic            r_en_q;
  logic            r_gh;
  logic            r_gl;
  logic            r_fault;
  logic            w_fault_s;
  logic [DT_W-1:0] w_dt_load;
  logic            w_expire;
  logic            w_force_off;

  sync_ff #(
    .RST_VAL (1'b1)
  ) u_fault_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (fault_n),
    .o_q   (w_fault_s)
  );

  assign w_dt_load   = (dt == '0) ? C_DT_ONE : dt;
  assign w_expire    = (r_cnt <= C_DT_ONE);
  assign w_force_off = !w_fault_s || r_fault || !r_en_q;

  // Gate outputs are computed from the next state so they change on the same edge as it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_s_q   <= 1'b0;
      r_en_q  <= 1'b0;
      r_gh    <= 1'b0;
      r_gl    <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_s_q  <= s;
      r_en_q <= en;
      r_gh   <= 1'b0;
      r_gl   <= 1'b0;

      if (!w_fault_s) begin
        r_fault <= 1'b1;
      end else if (clr_fault) begin
        r_fault <= 1'b0;
      end

      if (w_force_off) begin
        r_state <= ST_OFF;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          ST_OFF: begin
            r_state <= r_s_q ? ST_DEAD_H : ST_DEAD_L;
            r_cnt   <= w_dt_load;
          end
          ST_DEAD_H: begin
            if (!r_s_q) begin
              r_state <= ST_LOW;
              r_cnt   <= '0;
              r_gl    <= 1'b1;
            end else if (w_expire) begin
              r_state <= ST_HIGH;
              r_cnt   <= '0;
              r_gh    <= 1'b1;
            end else begin
              r_cnt <= r_cnt - C_DT_ONE;
            end
          end
          ST_HIGH: begin
            if (!r_s_q) begin
              r_state <= ST_DEAD_L;
              r_cnt   <= w_dt_load;
            end else begin
              r_gh <= 1'b1;
            end
          end
          ST_DEAD_L: begin
            if (r_s_q) begin
              r_state <= ST_HIGH;
              r_cnt   <= '0;
              r_gh    <= 1'b1;
            end else if (w_expire) begin
              r_state <= ST_LOW;
              r_cnt   <= '0;
              r_gl    <= 1'b1;
            end else begin
              r_cnt <= r_cnt - C_DT_ONE;
            end
          end
          ST_LOW: begin
            if (r_s_q) begin
              r_state <= ST_DEAD_H;
              r_cnt   <= w_dt_load;
            end else begin
              r_gl <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign gh    = r_gh;
  assign gl    = r_gl;
  assign fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_deadtime_gen.sv
`default_nettype none
// Directed bench for deadtime_gen: inputs change and outputs are sampled 1 ns after each rising edge.
module tb_deadtime_gen;
  import vsi_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       s;
  logic [7:0] dt;
  logic       fault_n;
  logic       clr_fault;
  logic       gh;
  logic       gl;
  logic       fault;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap_cnt = 0;

  deadtime_gen #(
    .DT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .s         (s),
    .dt        (dt),
    .fault_n   (fault_n),
    .clr_fault (clr_fault),
    .gh        (gh),
    .gl        (gl),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gh === 1'b1 && gl === 1'b1) overlap_cnt++;
  end

  task automatic adv(input int m);
    repeat (m) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int hi_time;
    hi_time   = PWM_PERIOD * 2 / 5;
    rst_n     = 1'b0;
    en        = 1'b0;
    s         = 1'b0;
    dt        = 8'd5;
    fault_n   = 1'b1;
    clr_fault = 1'b0;

    // Reset state
    adv(2);
    chk("rst_gh", {31'd0, gh}, 32'd0);
    chk("rst_gl", {31'd0, gl}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    rst_n = 1'b1;
    adv(2);

    // Enable with s=0: DEAD_L entered at N+1, gl rises at N+6
    en = 1'b1;
    adv(6);
    chk("en_dead_gl", {31'd0, gl}, 32'd0);
    adv(1);
    chk("en_low_gl", {31'd0, gl}, 32'd1);
    adv(3);

    // Normal rising handover, dt=5
    s = 1'b1;
    adv(1);
    chk("up_sq_gl", {31'd0, gl}, 32'd1);
    adv(1);
    chk("up_gl_fall", {30'd0, gh, gl}, 32'd0);
    adv(4);
    chk("up_dead_gh", {31'd0, gh}, 32'd0);
    adv(1);
    chk("up_gh_rise", {30'd0, gh, gl}, 32'b10);
    adv(hi_time - 7);

    // Mirror falling handover
    s = 1'b0;
    adv(1);
    chk("dn_sq_gh", {31'd0, gh}, 32'd1);
    adv(1);
    chk("dn_gh_fall", {30'd0, gh, gl}, 32'd0);
    adv(4);
    chk("dn_dead_gl", {31'd0, gl}, 32'd0);
    adv(1);
    chk("dn_gl_rise", {30'd0, gh, gl}, 32'b01);
    adv(3);

    // Narrow pulse: dt=10, s high 4 clocks
    dt = 8'd10;
    s  = 1'b1;
    adv(2);
    chk("np_gl_drop", {30'd0, gh, gl}, 32'd0);
    adv(2);
    s = 1'b0;
    adv(1);
    chk("np_still_dead", {30'd0, gh, gl}, 32'd0);
    adv(1);
    chk("np_gl_back", {30'd0, gh, gl}, 32'b01);
    adv(3);

    // dt=0 behaves as 1
    dt = 8'd0;
    s  = 1'b1;
    adv(2);
    chk("dt0_up_gap", {30'd0, gh, gl}, 32'd0);
    adv(1);
    chk("dt0_up_gh", {30'd0, gh, gl}, 32'b10);
    s = 1'b0;
    adv(1);
    chk("dt0_dn_hold", {30'd0, gh, gl}, 32'b10);
    adv(1);
    chk("dt0_dn_gap", {30'd0, gh, gl}, 32'd0);
    adv(1);
    chk("dt0_dn_gl", {30'd0, gh, gl}, 32'b01);
    adv(2);

    // dt changed mid-count is ignored
    dt = 8'd20;
    s  = 1'b1;
    adv(6);
    dt = 8'd3;
    adv(15);
    chk("dtchg_gh_wait", {30'd0, gh, gl}, 32'd0);
    adv(1);
    chk("dtchg_gh_rise", {30'd0, gh, gl}, 32'b10);
    adv(2);

    // One-clock fault pulse while HIGH
    fault_n = 1'b0;
    adv(1);
    fault_n = 1'b1;
    chk("flt_e0_gh", {31'd0, gh}, 32'd1);
    adv(1);
    chk("flt_e1", {30'd0, gh, fault}, 32'b10);
    adv(1);
    chk("flt_e2", {29'd0, gh, gl, fault}, 32'b001);
    adv(3);
    chk("flt_latched", {29'd0, gh, gl, fault}, 32'b001);

    // clr_fault coinciding with fault_s low keeps the latch
    fault_n = 1'b0;
    adv(2);
    clr_fault = 1'b1;
    adv(1);
    clr_fault = 1'b0;
    chk("clr_blocked", {31'd0, fault}, 32'd1);
    fault_n = 1'b1;
    adv(2);
    chk("flt_hold", {31'd0, fault}, 32'd1);
    clr_fault = 1'b1;
    adv(1);
    clr_fault = 1'b0;
    chk("clr_ok", {29'd0, gh, gl, fault}, 32'b000);
    adv(3);
    chk("clr_dead", {30'd0, gh, gl}, 32'd0);
    adv(1);
    chk("clr_gh", {30'd0, gh, gl}, 32'b10);

    // en dropped mid-DEAD_H
    s = 1'b0;
    adv(5);
    chk("en_pre_low", {30'd0, gh, gl}, 32'b01);
    s = 1'b1;
    adv(2);
    en = 1'b0;
    adv(2);
    chk("en_off_a", {30'd0, gh, gl}, 32'd0);
    adv(1);
    chk("en_off_b", {30'd0, gh, gl}, 32'd0);
    adv(3);

    // OFF exit: DEAD at N+1, gate at N+1+3
    en = 1'b1;
    adv(4);
    chk("off_exit_dead", {30'd0, gh, gl}, 32'd0);
    adv(1);
    chk("off_exit_gh", {30'd0, gh, gl}, 32'b10);
    adv(2);

    // Reset mid-HIGH
    rst_n = 1'b0;
    adv(1);
    chk("rst_mid", {29'd0, gh, gl, fault}, 32'd0);
    rst_n = 1'b1;
    adv(4);
    chk("rst_restart_dead", {30'd0, gh, gl}, 32'd0);
    adv(1);
    chk("rst_restart_gh", {30'd0, gh, gl}, 32'b10);

    chk("no_overlap", overlap_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
